// File: rtl/video_cfg_ctrl.sv
// Frame-synchronous configuration controller: parses the MCU byte stream, forwards OSD
// frames and applies shadowed video/audio settings atomically at vertical sync.
module video_cfg_ctrl #(
    parameter logic [8:0] AUDIO_DIV_RESET = 9'd327,
    parameter int         VS_TIMEOUT_LOG2 = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mcu_start,
    input  logic       mcu_strobe,
    input  logic [7:0] mcu_data,
    input  logic       vs_n,
    output logic       osd_start,
    output logic       osd_strobe,
    output logic [7:0] osd_data,
    output logic [1:0] system_scanlines,
    output logic [1:0] system_volume,
    output logic       system_wide_screen,
    output logic [8:0] audio_div,
    output logic       cfg_pending
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_OSD, S_ADDR, S_DATA, S_IGNORE} state_t;

    localparam logic [VS_TIMEOUT_LOG2-1:0] WD_ONE = 1;

    state_t state, state_nxt, state_eff;

    logic       osd_start_d, osd_fwd, addr_load, sh_we, apply_cmd;
    logic       osd_cmd_pend_p1;
    logic [7:0] cmd_byte_p1;
    logic [2:0] addr;
    logic       vs_n_p1, vs_fall, wd_expire, apply;
    logic [VS_TIMEOUT_LOG2-1:0] wd;

    logic [1:0] sh_scanlines, sh_volume;
    logic       sh_wide;
    logic [8:0] sh_audio_div;

    // mcu_start overrides the current state so a start+strobe cycle decodes as a command
    assign state_eff = mcu_start ? S_CMD : state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state_eff;
        if (mcu_strobe) begin
            case (state_eff)
                S_CMD: begin
                    if (mcu_data[7:4] == 4'h4)  state_nxt = S_OSD;
                    else if (mcu_data == 8'h50) state_nxt = S_ADDR;
                    else                        state_nxt = S_IGNORE;
                end
                S_ADDR:  state_nxt = S_DATA;
                default: state_nxt = state_eff;
            endcase
        end
    end

    always_comb begin
        osd_start_d = mcu_strobe && (state_eff == S_CMD) && (mcu_data[7:4] == 4'h4);
        apply_cmd   = mcu_strobe && (state_eff == S_CMD) && (mcu_data == 8'h51);
        osd_fwd     = mcu_strobe && (state_eff == S_OSD);
        addr_load   = mcu_strobe && (state_eff == S_ADDR);
        sh_we       = mcu_strobe && (state_eff == S_DATA);
    end

    assign vs_fall   = vs_n_p1 && !vs_n;
    assign wd_expire = &wd;
    assign apply     = vs_fall || apply_cmd || (wd_expire && cfg_pending);

    // OSD path: start pulse first, the command byte follows one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osd_start       <= 1'b0;
            osd_strobe      <= 1'b0;
            osd_data        <= 8'h00;
            osd_cmd_pend_p1 <= 1'b0;
            cmd_byte_p1     <= 8'h00;
        end else begin
            osd_start       <= osd_start_d;
            osd_cmd_pend_p1 <= osd_start_d;
            if (osd_start_d) cmd_byte_p1 <= mcu_data;
            osd_strobe      <= osd_fwd || osd_cmd_pend_p1;
            if (osd_fwd)              osd_data <= mcu_data;
            else if (osd_cmd_pend_p1) osd_data <= cmd_byte_p1;
        end
    end

    // Shadow capture and atomic apply; an apply in the same cycle as a write sees the old shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr               <= 3'd0;
            sh_scanlines       <= 2'd0;
            sh_volume          <= 2'd3;
            sh_wide            <= 1'b0;
            sh_audio_div       <= AUDIO_DIV_RESET;
            system_scanlines   <= 2'd0;
            system_volume      <= 2'd3;
            system_wide_screen <= 1'b0;
            audio_div          <= AUDIO_DIV_RESET;
            cfg_pending        <= 1'b0;
            vs_n_p1            <= 1'b1;
            wd                 <= '0;
        end else begin
            vs_n_p1 <= vs_n;
            if (addr_load)  addr <= mcu_data[2:0];
            else if (sh_we) addr <= addr + 3'd1;
            if (sh_we) begin
                case (addr)
                    3'd0:    sh_scanlines      <= mcu_data[1:0];
                    3'd1:    sh_volume         <= mcu_data[1:0];
                    3'd2:    sh_wide           <= mcu_data[0];
                    3'd3:    sh_audio_div[7:0] <= mcu_data;
                    3'd4:    sh_audio_div[8]   <= mcu_data[0];
                    default: ;
                endcase
            end
            if (apply) begin
                system_scanlines   <= sh_scanlines;
                system_volume      <= sh_volume;
                system_wide_screen <= sh_wide;
                audio_div          <= sh_audio_div;
            end
            if (sh_we)      cfg_pending <= 1'b1;
            else if (apply) cfg_pending <= 1'b0;
            if (vs_fall || apply) wd <= '0;
            else                  wd <= wd + WD_ONE;
        end
    end

endmodule

// File: doc/video_cfg_ctrl.md
# video_cfg_ctrl

Frame-synchronous configuration controller for the video/HDMI output path. Parses the MCU byte stream (start pulse, byte strobes, 8-bit data) and routes OSD frames unchanged to the OSD overlay. Captures configuration writes (scanlines, volume, wide screen, audio clock divisor) into shadow registers and applies them atomically at the next vertical sync, so scandoubler, audio scaler and HDMI encoder never change mid-frame. A watchdog forces the apply when no vertical sync arrives.

## Interface
Parameters:
- AUDIO_DIV_RESET, 9'd327, reset value of audio_div (31.5 MHz / 48 kHz / 2 − 1)
- VS_TIMEOUT_LOG2, 21, watchdog width; forced apply after 2^N − 1 cycles without a vs_n falling edge

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mcu_start  in  1  one-cycle pulse; begins a new frame
- mcu_strobe  in  1  one-cycle pulse; mcu_data valid
- mcu_data  in  8  frame byte
- vs_n  in  1  vertical sync, active low, clk domain
- osd_start  out  1  start pulse to OSD
- osd_strobe  out  1  byte strobe to OSD
- osd_data  out  8  byte to OSD
- system_scanlines  out  2  applied scanline mode
- system_volume  out  2  applied volume
- system_wide_screen  out  1  applied wide-screen flag
- audio_div  out  9  applied audio clock divisor
- cfg_pending  out  1  shadow written but not yet applied

## Operation
- Frame layout: the first strobed byte after mcu_start is the command byte.
  - 0x40–0x4F: OSD frame.
  - 0x50: CFG_WRITE; following bytes are address, then data.
  - 0x51: CFG_APPLY; immediate apply.
  - Any other command: the rest of the frame is ignored.
- FSM states: IDLE, CMD, OSD, ADDR, DATA, IGNORE. Reset state is IDLE.
  - mcu_start in any state → CMD. This aborts the current frame; no shadow rollback.
  - mcu_start and mcu_strobe in the same cycle: state goes to CMD and that byte is the command byte.
  - CMD, byte 0x4x → OSD: pulse osd_start, then forward the command byte.
  - CMD, byte 0x50 → ADDR.
  - CMD, byte 0x51 → IGNORE after an apply.
  - CMD, any other byte → IGNORE.
  - OSD: every strobed byte is forwarded until the next mcu_start.
  - ADDR: latch a 3-bit address from data[2:0] → DATA.
  - DATA: write the shadow register at the address. Address increments modulo 8; the FSM stays in DATA.
- Shadow address map:
  - 0: scanlines = data[1:0]
  - 1: volume = data[1:0]
  - 2: wide = data[0]
  - 3: audio_div[7:0]
  - 4: audio_div[8] = data[0]
  - 5–7: write ignored; address still increments (7 wraps to 0).
- Any shadow write sets cfg_pending. The write is accepted even if the value is unchanged.
- Apply: all four outputs load from the shadow in one cycle and cfg_pending clears. Triggers:
  - (a) vs_n falling edge (registered vs_n = 1, current vs_n = 0);
  - (b) CFG_APPLY command byte;
  - (c) watchdog expiry while cfg_pending = 1.
  - With no pending write, (a) and (c) still copy; the outputs are unchanged.
- Watchdog: VS_TIMEOUT_LOG2-bit counter.
  - Cleared on every vs_n falling edge or apply.
  - Otherwise increments; on reaching all-ones, applies if pending, then wraps to 0.
- Apply and shadow write in the same cycle: the apply copies the pre-write shadow; the new write stays pending (cfg_pending = 1).

## Timing
- Reset (async assert, sync behaviour on release):
  - osd_start = 0, osd_strobe = 0, osd_data = 0
  - system_scanlines = 0, system_volume = 3, system_wide_screen = 0, audio_div = AUDIO_DIV_RESET
  - cfg_pending = 0
  - Shadow registers equal these output values; watchdog = 0; vs_n history register = 1.
- OSD command strobe at cycle T: osd_start = 1 at T+1; osd_strobe = 1 with osd_data = command byte at T+2.
- OSD data strobe at T: osd_strobe = 1 with osd_data at T+1.
- osd_data holds its value between strobes; osd_start and osd_strobe are single-cycle.
- Input constraint: mcu_strobe pulses are at least 3 cycles apart. Closer spacing is unsupported; the implementation need not detect it.
- Config data strobe at T: shadow updated and cfg_pending = 1 at T+1.
- vs_n first sampled low at T: outputs updated and cfg_pending = 0 at T+1.
- CFG_APPLY strobe at T: outputs updated at T+1.

## Test plan
- Reset, then CFG_WRITE: start, 0x50, 0x01, 0x02 → outputs unchanged and cfg_pending = 1. vs_n falls at T → system_volume = 2 and cfg_pending = 0 at T+1.
- Burst start, 0x50, 0x03, 0x2C, 0x01 (auto-increment) → after vs_n fall, audio_div = 9'h12C; other outputs unchanged.
- OSD frame start, 0x41, 0xAA, 0x55 with 4-cycle strobe spacing → osd_start one cycle after the 0x41 strobe, then osd_strobe carrying 0x41, 0xAA, 0x55 each at strobe+1. Config outputs untouched.
- vs_n held high, VS_TIMEOUT_LOG2 = 8, write wide = 1 → system_wide_screen = 1 exactly when the watchdog reaches 255.
- Write scanlines = 3 with the data strobe in the same cycle as the vs_n falling edge → scanlines stays 0 and cfg_pending = 1; next vs_n fall → scanlines = 3.
- mcu_start mid-OSD frame followed by 0x99, 0x12 → no further osd_strobe. Then start, 0x50, 0x07, 0x01, 0x03 → address 7 is ignored, the wrap writes scanlines = 3, and start, 0x51 applies immediately.
